fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter: DEPTH, default 4, number of buffered instruction entries (power of two, >=2).
REQ-002 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk_i  input  1  sole clock, rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-low.
REQ-005 imem_req_o  output  1  instruction-memory request valid.
REQ-006 imem_addr_o  output  32  word-aligned fetch address.
REQ-007 imem_gnt_i  input  1  memory accepted request this cycle.
REQ-008 imem_rvalid_i  input  1  read data valid.
REQ-009 imem_rdata_i  input  32  instruction word.
REQ-010 redirect_i  input  1  branch/JAL/JALR taken; flush queue and refetch.
REQ-011 redirect_pc_i  input  32  new fetch address.
REQ-012 instr_valid_o  output  1  queue head valid to decode.
REQ-013 instr_o  output  32  queue head instruction.
REQ-014 instr_pc_o  output  32  PC of queue head.
REQ-015 instr_ready_i  input  1  decode consumes head when valid and ready.

Function
REQ-016 FSM states: IDLE, WAIT_GNT, WAIT_RVALID; at most one request outstanding.
REQ-017 IDLE -> WAIT_GNT when (count + in_flight) < DEPTH; imem_req_o asserted in WAIT_GNT only.
REQ-018 imem_req_o and imem_addr_o hold stable in WAIT_GNT until imem_gnt_i.
REQ-019 WAIT_GNT -> WAIT_RVALID on imem_gnt_i; fetch_pc advances by 4 on grant, 32-bit wrap (32'hFFFF_FFFC -> 0).
REQ-020 WAIT_RVALID -> IDLE on imem_rvalid_i; {fetch address, imem_rdata_i} pushed same edge unless discarded; earliest push one cycle after grant.
REQ-021 Credit rule guarantees no push when full; rvalid arriving with no outstanding request is ignored.
REQ-022 Pop when instr_valid_o and instr_ready_i; push and pop in same cycle leave count unchanged.
REQ-023 instr_valid_o = (count != 0); instr_o/instr_pc_o driven from head, combinational from storage, zero when empty.
REQ-024 Redirect: next edge count := 0, fetch_pc := {redirect_pc_i[31:2],2'b00}, FSM -> IDLE; redirect wins over simultaneous push and pop.
REQ-025 Redirect during WAIT_GNT: request withdrawn; new address issued no earlier than next cycle.
REQ-026 Redirect during WAIT_RVALID (or same cycle as grant): discard flag set; the pending response is dropped, then issue resumes at redirect address.
REQ-027 Redirect coincident with imem_rvalid_i: that response dropped.
REQ-028 Throughput: with gnt and rvalid each one cycle, one instruction per two cycles; no combinational path from instr_ready_i to imem_req_o.

Reset
REQ-029 While rst_i low: count 0, FSM IDLE, discard 0, fetch_pc RESET_PC, imem_req_o 0, imem_addr_o RESET_PC, instr_valid_o 0, instr_o 0, instr_pc_o 0.
REQ-030 Reset asserted mid-transaction abandons it; a later rvalid for that request is ignored.
REQ-031 First request asserted in the first cycle after rst_i deasserts.

Structure
REQ-032 Package fetch_pkg holds state enum fetch_state_t, entry struct {pc[31:0], instr[31:0]}, and DEPTH/RESET_PC defaults.
REQ-033 Storage in sub-module fetch_fifo (DEPTH entries, wrapping read/write pointers, count, synchronous flush); FSM and credit logic in fetch_queue.

Verification
REQ-034 Reset release, gnt and rvalid one cycle each, data 0x00000013, 0x00500093 -> requests at 0x0, 0x4; instr_pc_o 0x0 then 0x4; valid after first rvalid.
REQ-035 instr_ready_i held 0 with DEPTH=4 -> exactly 4 grants, imem_req_o then stays 0; one pop -> exactly one further request.
REQ-036 Redirect to 0x103 while WAIT_RVALID for 0x8 -> 0x8 response dropped, queue empty, next imem_addr_o 0x100.
REQ-037 imem_gnt_i held 0 for 5 cycles -> imem_req_o and imem_addr_o stable throughout; redirect to 0x40 in cycle 3 -> address 0x40 from next cycle.
REQ-038 Redirect to 0xFFFFFFFC, two fetches -> instr_pc_o 0xFFFFFFFC then 0x00000000.
REQ-039 rst_i low mid WAIT_RVALID, rvalid arrives during reset -> no entry pushed, all outputs at reset values.

Source files
------------

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and defaults for the instruction fetch queue.
//   fetch_state_t : request FSM state (IDLE, WAIT_GNT, WAIT_RVALID)
//   fetch_entry_t : one buffered instruction {pc, instr}
//   DEPTH_DEFAULT / RESET_PC_DEFAULT : parameter defaults for fetch_queue
// ---------------------------------------------------------------------------
package fetch_pkg;

    localparam int          DEPTH_DEFAULT    = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_GNT    = 2'd1,
        WAIT_RVALID = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// DEPTH-entry instruction buffer with wrapping read/write pointers.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous clear of pointers and count (wins over push/pop)
//   push       : write push_data at the tail
//   push_data  : entry to write
//   pop        : drop the head entry
//   head       : entry at the read pointer (valid only when count != 0)
//   count      : number of stored entries, 0..DEPTH
// The caller guarantees no push when full and no pop when empty.
// ---------------------------------------------------------------------------
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = DEPTH_DEFAULT,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    output fetch_entry_t  head,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: nothing is visible until count says so.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Instruction fetch unit: issues one word request at a time to instruction
// memory, buffers responses with their PCs, and hands them to decode.
//   clk_i, rst_i        : clock, asynchronous active-low reset
//   imem_req_o          : request valid (high only in WAIT_GNT, registered)
//   imem_addr_o         : word-aligned fetch address, stable until grant
//   imem_gnt_i          : memory accepted the request this cycle
//   imem_rvalid_i       : read data valid for the outstanding request
//   imem_rdata_i        : instruction word
//   redirect_i          : taken branch/jump; flush queue, refetch
//   redirect_pc_i       : new fetch address (low two bits ignored)
//   instr_valid_o       : queue head valid
//   instr_o, instr_pc_o : queue head word and PC, zero when empty
//   instr_ready_i       : decode consumes head when valid and ready
//   state_o             : current FSM state (debug visibility)
//
// Handshakes: imem request is a valid/grant pair -- imem_req_o and
// imem_addr_o stay fixed until a cycle where imem_req_o && imem_gnt_i.
// The decode side is valid/ready: a transfer happens in a cycle with
// instr_valid_o && instr_ready_i, and valid never depends on ready.
// ---------------------------------------------------------------------------
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = DEPTH_DEFAULT,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i,
    output logic [1:0]  state_o
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_state_t  state;
    logic [31:0]   fetch_pc;   // next address to request
    logic [31:0]   req_pc;     // address of the request awaiting rvalid
    logic          discard;    // a granted request's response must be dropped
    logic          req;

    logic [CW-1:0] count;
    fetch_entry_t  head;
    fetch_entry_t  push_data;
    logic          push;
    logic          pop;
    logic          credit_idle;
    logic          credit_chain;
    logic          unused_pc_lsbs;

    assign unused_pc_lsbs = ^redirect_pc_i[1:0];

    // From IDLE nothing is in flight, so credit is just free space. When a
    // response lands, the pushed word occupies a slot, so chaining straight
    // into the next request needs room for one more. Both use the registered
    // count only, keeping instr_ready_i out of the request path.
    assign credit_idle  = (count < DEPTH_C);
    assign credit_chain = ((count + CW'(1)) < DEPTH_C);

    assign push = (state == WAIT_RVALID) && imem_rvalid_i && !redirect_i;
    assign pop  = instr_valid_o && instr_ready_i && !redirect_i;

    assign push_data.pc    = req_pc;
    assign push_data.instr = imem_rdata_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            discard  <= 1'b0;
            req      <= 1'b0;
        end else if (redirect_i) begin
            state    <= IDLE;
            req      <= 1'b0;
            fetch_pc <= {redirect_pc_i[31:2], 2'b00};
            // Remember to drop a response only if a granted request is still
            // waiting for it after this edge.
            case (state)
                WAIT_GNT:    discard <= imem_gnt_i;
                WAIT_RVALID: discard <= !imem_rvalid_i;
                default:     discard <= discard && !imem_rvalid_i;
            endcase
        end else begin
            case (state)
                IDLE: begin
                    if (imem_rvalid_i) begin
                        discard <= 1'b0;
                    end
                    // A stale response still owed blocks new issue, keeping
                    // at most one request outstanding.
                    if ((!discard || imem_rvalid_i) && credit_idle) begin
                        state <= WAIT_GNT;
                        req   <= 1'b1;
                    end
                end
                WAIT_GNT: begin
                    if (imem_gnt_i) begin
                        state    <= WAIT_RVALID;
                        req      <= 1'b0;
                        req_pc   <= fetch_pc;
                        fetch_pc <= fetch_pc + 32'd4;
                    end
                end
                WAIT_RVALID: begin
                    if (imem_rvalid_i) begin
                        if (credit_chain) begin
                            state <= WAIT_GNT;
                            req   <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    req   <= 1'b0;
                end
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk_i),
        .rst_n     (rst_i),
        .flush     (redirect_i),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign imem_req_o    = req;
    assign imem_addr_o   = fetch_pc;
    assign instr_valid_o = (count != '0);
    assign instr_o       = instr_valid_o ? head.instr : 32'h0;
    assign instr_pc_o    = instr_valid_o ? head.pc    : 32'h0;
    assign state_o       = state;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_GNT    = 2'd1;
    localparam logic [1:0] S_RVALID = 2'd2;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i = 1'b0;
    logic [1:0]  state_o;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];
    logic [31:0] word;
    int          req_cycles;

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected $finish");
        $fatal(1);
    end

    fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_ready_i (instr_ready_i),
        .state_o       (state_o)
    );

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic grant();
        imem_gnt_i = 1'b1;
        step();
        imem_gnt_i = 1'b0;
    endtask

    task automatic respond(input logic [31:0] w);
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = w;
        step();
        imem_rvalid_i = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_i    = 1'b1;
        redirect_pc_i = pc;
        step();
        redirect_i    = 1'b0;
    endtask

    task automatic pop_one();
        instr_ready_i = 1'b1;
        step();
        instr_ready_i = 1'b0;
    endtask

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, expv);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req"},   32'(imem_req_o),    32'h0);
        check({tag, " addr"},  imem_addr_o,        32'h0);
        check({tag, " valid"}, 32'(instr_valid_o), 32'h0);
        check({tag, " instr"}, instr_o,            32'h0);
        check({tag, " pc"},    instr_pc_o,         32'h0);
        check({tag, " state"}, 32'(state_o),       32'(S_IDLE));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // Reset held low across two edges
        step();
        step();
        check_reset_outputs("reset");

        // Release: first request in the first cycle after release
        rst_i = 1'b1;
        step();
        check("first req", 32'(imem_req_o), 32'h1);
        check("first addr", imem_addr_o, 32'h0);
        check("first state", 32'(state_o), 32'(S_GNT));

        grant();
        check("after gnt req", 32'(imem_req_o), 32'h0);
        check("after gnt state", 32'(state_o), 32'(S_RVALID));
        check("after gnt valid", 32'(instr_valid_o), 32'h0);

        respond(32'h0000_0013);
        check("rv0 valid", 32'(instr_valid_o), 32'h1);
        check("rv0 instr", instr_o, 32'h0000_0013);
        check("rv0 pc", instr_pc_o, 32'h0);
        check("rv0 next req", 32'(imem_req_o), 32'h1);
        check("rv0 next addr", imem_addr_o, 32'h4);

        grant();
        respond(32'h0050_0093);
        check("rv1 head pc", instr_pc_o, 32'h0);
        check("rv1 next addr", imem_addr_o, 32'h8);

        pop_one();
        check("pop0 pc", instr_pc_o, 32'h4);
        check("pop0 instr", instr_o, 32'h0050_0093);

        // Redirect while the 0x8 response is pending
        grant();
        check("rd pending state", 32'(state_o), 32'(S_RVALID));
        redirect(32'h0000_0103);
        check("rd valid", 32'(instr_valid_o), 32'h0);
        check("rd req", 32'(imem_req_o), 32'h0);
        check("rd addr", imem_addr_o, 32'h0000_0100);
        step();
        check("rd wait stale req", 32'(imem_req_o), 32'h0);
        respond(32'hDEAD_BEEF);
        check("rd stale dropped", 32'(instr_valid_o), 32'h0);
        check("rd resume req", 32'(imem_req_o), 32'h1);
        check("rd resume addr", imem_addr_o, 32'h0000_0100);

        // Grant stalled; redirect in the third stalled cycle
        step();
        check("stall1 req", 32'(imem_req_o), 32'h1);
        check("stall1 addr", imem_addr_o, 32'h0000_0100);
        step();
        check("stall2 req", 32'(imem_req_o), 32'h1);
        check("stall2 addr", imem_addr_o, 32'h0000_0100);
        redirect(32'h0000_0040);
        check("stall3 req", 32'(imem_req_o), 32'h0);
        check("stall3 addr", imem_addr_o, 32'h0000_0040);
        step();
        check("stall4 req", 32'(imem_req_o), 32'h1);
        check("stall4 addr", imem_addr_o, 32'h0000_0040);
        grant();
        respond(32'h1111_1111);
        check("x40 pc", instr_pc_o, 32'h0000_0040);
        check("x40 instr", instr_o, 32'h1111_1111);
        pop_one();
        check("empty valid", 32'(instr_valid_o), 32'h0);
        check("empty instr", instr_o, 32'h0);
        check("empty pc", instr_pc_o, 32'h0);

        // Address wrap
        redirect(32'hFFFF_FFFC);
        check("wrap addr", imem_addr_o, 32'hFFFF_FFFC);
        step();
        check("wrap req", 32'(imem_req_o), 32'h1);
        grant();
        check("wrap next addr", imem_addr_o, 32'h0);
        respond(32'hAAAA_0001);
        check("wrap pc0", instr_pc_o, 32'hFFFF_FFFC);
        check("wrap instr0", instr_o, 32'hAAAA_0001);
        grant();
        respond(32'hAAAA_0002);
        pop_one();
        check("wrap pc1", instr_pc_o, 32'h0);
        check("wrap instr1", instr_o, 32'hAAAA_0002);

        // Redirect coincident with rvalid and a pop
        grant();
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hBBBB_BBBB;
        instr_ready_i = 1'b1;
        redirect(32'h0000_0200);
        imem_rvalid_i = 1'b0;
        instr_ready_i = 1'b0;
        check("coinc valid", 32'(instr_valid_o), 32'h0);
        check("coinc req", 32'(imem_req_o), 32'h0);
        check("coinc addr", imem_addr_o, 32'h0000_0200);
        step();
        check("coinc issue req", 32'(imem_req_o), 32'h1);
        check("coinc issue addr", imem_addr_o, 32'h0000_0200);

        // Fill with decode stalled: exactly four grants
        for (int i = 0; i < 4; i++) begin
            check("fill req", 32'(imem_req_o), 32'h1);
            check("fill addr", imem_addr_o, 32'h0000_0200 + 32'(4 * i));
            grant();
            word = $urandom_range(32'hFFFF, 0) | 32'h1234_0000;
            exp_q.push_back(word);
            respond(word);
        end
        check("full req", 32'(imem_req_o), 32'h0);
        check("full state", 32'(state_o), 32'(S_IDLE));
        check("full head pc", instr_pc_o, 32'h0000_0200);
        check("full head instr", instr_o, exp_q[0]);
        req_cycles = 0;
        repeat (6) begin
            step();
            if (imem_req_o) req_cycles++;
        end
        check("full no req", 32'(req_cycles), 32'h0);

        // One pop frees exactly one request
        void'(exp_q.pop_front());
        pop_one();
        check("pop1 req same edge", 32'(imem_req_o), 32'h0);
        step();
        check("refill req", 32'(imem_req_o), 32'h1);
        check("refill addr", imem_addr_o, 32'h0000_0210);
        grant();
        word = $urandom_range(32'hFFFF, 0) | 32'h5678_0000;
        exp_q.push_back(word);
        respond(word);
        check("refill state", 32'(state_o), 32'(S_IDLE));
        req_cycles = 0;
        repeat (6) begin
            step();
            if (imem_req_o) req_cycles++;
        end
        check("refill no req", 32'(req_cycles), 32'h0);

        // Drain against the scoreboard
        instr_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain valid", 32'(instr_valid_o), 32'h1);
            check("drain instr", instr_o, exp_q.pop_front());
            step();
        end
        instr_ready_i = 1'b0;
        check("drained valid", 32'(instr_valid_o), 32'h0);
        check("drained state", 32'(state_o), 32'(S_GNT));

        // Reset during WAIT_RVALID; response arrives during and after reset
        grant();
        check("pre-reset state", 32'(state_o), 32'(S_RVALID));
        rst_i = 1'b0;
        #1;
        check_reset_outputs("async reset");
        respond(32'hCCCC_CCCC);
        check_reset_outputs("rvalid in reset");
        rst_i = 1'b1;
        respond(32'hCCCC_CCCD);
        check("late rvalid valid", 32'(instr_valid_o), 32'h0);
        check("late rvalid req", 32'(imem_req_o), 32'h1);
        check("late rvalid addr", imem_addr_o, 32'h0);

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
